can_rx_data_unpack: RTL and testbench
=====================================

Name: can_rx_data_unpack

Overview:
- Receive-side counterpart of the transmit DLC encoder.
- Takes the 4-bit DLC latched from the received control field, then deserialises the de-stuffed data-field bit stream (MSB first per byte) into a 64-bit word.
- Byte k of the frame lands at data[k*8 +: 8]; byte 0 is the first received byte. This matches the transmit-side packing.
- Sits between the bit de-stuffer and the frame buffer / CRC checker.

Parameters:
- MAX_BYTES, 8, maximum data bytes per frame (classic CAN). Sets the clamp value and the data width (MAX_BYTES*8).

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: control field done, dlc_in valid this cycle
- dlc_in  in  4  received DLC
- bit_valid  in  1  qualifies bit_in (one de-stuffed bit per assertion)
- bit_in  in  1  de-stuffed data-field bit
- abort  in  1  bus/stuff error; drop the current frame
- out_ready  in  1  downstream accepts the result
- out_valid  out  1  result held valid until accepted
- data_out  out  64  assembled data, unused bytes forced to 0
- dlc_out  out  4  effective DLC, clamped to MAX_BYTES
- byte_mask  out  8  bit k set if byte k was received (thermometer code)
- busy  out  1  high in RECV
- overrun  out  1  one-cycle pulse: start arrived while not IDLE
- dlc_err  out  1  see Optional Feature

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE. All outputs are 0. Bit counter and shift register cleared. rst has priority over every other input.
- States are IDLE, RECV and HOLD.
- IDLE:
  - On start, latch n = min(dlc_in, MAX_BYTES) and clear data_out.
  - n=0: go to HOLD next cycle with data_out=0, byte_mask=0, dlc_out=0.
  - n>0: go to RECV with bit counter = 0.
  - bit_valid in IDLE is ignored.
- RECV:
  - Each bit_valid shifts bit_in into the current byte, MSB first.
  - After the 8th bit of byte k, the byte is written to data_out[k*8 +: 8] in the same edge.
  - Counter width is 6 bits. Total bits = n*8 (max 64).
  - The edge that samples bit n*8-1 moves the state to HOLD. out_valid rises in the following cycle, so latency is 1 clk after the last bit's sampling edge.
  - busy is high in RECV.
- HOLD:
  - out_valid=1. data_out, dlc_out and byte_mask are stable.
  - byte_mask = (1<<n)-1.
  - Leave to IDLE on the edge where out_valid && out_ready. out_valid is 0 the next cycle.
  - bit_valid in HOLD is ignored. Extra bits are CRC-field bits and belong to another block.
- start in RECV or HOLD: ignored. overrun pulses for 1 cycle; the current frame is unaffected.
- start and acceptance in the same cycle in HOLD: the start is processed, not an overrun. The block leaves HOLD and latches the new DLC, entering RECV or HOLD(n=0) next cycle. This allows back-to-back frames.
- abort in RECV or HOLD: go to IDLE next edge, out_valid=0, data cleared. No overrun or dlc_err. abort in IDLE: no effect. abort together with start in IDLE: abort wins and the start is dropped.
- dlc_in values 9..15: treated as 8, per CAN 2.0 classic. dlc_out = 8.

Optional Feature:
- Macro: CAN_RX_DLC_ERR_EN.
- Defined: a start with dlc_in > MAX_BYTES raises dlc_err in HOLD alongside out_valid. dlc_err clears with acceptance. Data is still received clamped to MAX_BYTES.
- Undefined: dlc_err is tied to 0 and the clamp is silent. All other behaviour is identical.

Test Plan:
- dlc_in=3; bits for 0xA5, 0x3C, 0xFF, MSB first, one per cycle; out_ready=1 -> out_valid 1 clk after the 24th bit; data_out=64'h0000_0000_00FF_3CA5; byte_mask=8'h07; dlc_out=3.
- dlc_in=0; out_ready=0 for 5 cycles, then 1 -> out_valid rises 1 clk after start and holds with data_out=0, byte_mask=0 until the accept edge; then IDLE.
- dlc_in=8; 64 bits with gaps in bit_valid -> data_out byte k equals byte k sent; byte_mask=8'hFF; bits sent while out_valid is held do not change data_out.
- dlc_in=4'hF with the macro defined -> dlc_out=8, dlc_err=1 with out_valid. Without the macro -> dlc_err=0 and data identical.
- dlc_in=4; abort after 13 bits; then a new start with dlc_in=1 and 0x81 -> no out_valid for the aborted frame; second result data_out=64'h81, byte_mask=8'h01.
- start pulse mid-RECV -> overrun is a 1-cycle pulse and the current result is unaffected. start in the same cycle as acceptance -> no overrun; the new frame is received correctly.
- rst asserted mid-RECV -> next cycle all outputs are 0 and state is IDLE; a subsequent frame is received normally.

Source files
------------

// File: rtl/can_rx_data_unpack.sv
// CAN receive data-field deserialiser: DLC-clamped, MSB-first bytes packed into a 64-bit word.
// Optional `CAN_RX_DLC_ERR_EN raises dlc_err for received DLC values above MAX_BYTES.
module can_rx_data_unpack #(
    parameter int MAX_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             dlc_in,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   abort,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [MAX_BYTES*8-1:0] data_out,
    output logic [3:0]             dlc_out,
    output logic [MAX_BYTES-1:0]   byte_mask,
    output logic                   busy,
    output logic                   overrun,
    output logic                   dlc_err
);

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    localparam logic [3:0] MAX_DLC = 4'(MAX_BYTES);

    state_t                 state;
    logic [3:0]             n;
    logic [5:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [3:0]             n_in;
    logic [MAX_BYTES-1:0]   mask_n;
    logic [7:0]             byte_nxt;
    logic                   last_bit;
    logic                   accept;
    logic                   take_start;

`ifdef CAN_RX_DLC_ERR_EN
    logic dlc_big;
`else
    assign dlc_err = 1'b0;
`endif

    always_comb begin
        n_in = (dlc_in > MAX_DLC) ? MAX_DLC : dlc_in;
        mask_n = '0;
        for (int k = 0; k < MAX_BYTES; k++)
            mask_n[k] = (4'(k) < n);
        byte_nxt = {shreg, bit_in};
        last_bit = ({1'b0, bit_cnt} == ({n, 3'b000} - 7'd1));
        accept = out_valid && out_ready;
        // A start coinciding with acceptance opens the next frame back-to-back
        take_start = start && !abort &&
                     ((state == IDLE) || ((state == HOLD) && accept));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            dlc_out   <= '0;
            byte_mask <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef CAN_RX_DLC_ERR_EN
            dlc_big   <= 1'b0;
            dlc_err   <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                data_out  <= '0;
                dlc_out   <= '0;
                byte_mask <= '0;
`ifdef CAN_RX_DLC_ERR_EN
                dlc_err   <= 1'b0;
`endif
            end else if (take_start) begin
                n         <= n_in;
                dlc_out   <= n_in;
                bit_cnt   <= '0;
                data_out  <= '0;
                byte_mask <= '0;
`ifdef CAN_RX_DLC_ERR_EN
                dlc_big   <= (dlc_in > MAX_DLC);
                dlc_err   <= 1'b0;
`endif
                if (n_in == 4'd0) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    state     <= RECV;
                    out_valid <= 1'b0;
                    busy      <= 1'b1;
                end
            end else begin
                if (start && (state != IDLE))
                    overrun <= 1'b1;
                case (state)
                    RECV: if (bit_valid) begin
                        shreg   <= byte_nxt[6:0];
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt[2:0] == 3'd7) begin
                            for (int k = 0; k < MAX_BYTES; k++)
                                if (bit_cnt[5:3] == 3'(k))
                                    data_out[k*8 +: 8] <= byte_nxt;
                        end
                        if (last_bit) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            byte_mask <= mask_n;
`ifdef CAN_RX_DLC_ERR_EN
                            dlc_err   <= dlc_big;
`endif
                        end
                    end
                    HOLD: if (accept) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        data_out  <= '0;
                        dlc_out   <= '0;
                        byte_mask <= '0;
`ifdef CAN_RX_DLC_ERR_EN
                        dlc_err   <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_rx_data_unpack.sv
// Testbench for can_rx_data_unpack: directed and random frames against a byte-list model.
module tb_can_rx_data_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  dlc_in = '0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [63:0] data_out;
    logic [3:0]  dlc_out;
    logic [7:0]  byte_mask;
    logic        busy;
    logic        overrun;
    logic        dlc_err;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] fb [8];
    logic [3:0] fdlc;
    int         fn;

    can_rx_data_unpack #(.MAX_BYTES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dlc_in(dlc_in),
        .bit_valid(bit_valid), .bit_in(bit_in), .abort(abort),
        .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out),
        .dlc_out(dlc_out), .byte_mask(byte_mask), .busy(busy),
        .overrun(overrun), .dlc_err(dlc_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, data_out, 64'd0);
        chk({tag, "_dlc"}, 64'(dlc_out), 64'd0);
        chk({tag, "_mask"}, 64'(byte_mask), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ovr"}, 64'(overrun), 64'd0);
        chk({tag, "_err"}, 64'(dlc_err), 64'd0);
    endtask

    task automatic begin_frame(input logic [3:0] d, input bit with_accept);
        fdlc = d;
        fn = (d > 4'd8) ? 8 : int'(d);
        for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
        start = 1'b1;
        dlc_in = d;
        out_ready = with_accept;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        dlc_in = 4'($urandom);
    endtask

    task automatic feed(input int from, input int to, input bit gaps,
                        input int ovr_bit);
        for (int i = from; i < to; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bit_valid = 1'b0;
                bit_in = 1'($urandom);
                repeat ($urandom_range(1, 3)) tick();
            end
            if (i == fn * 8 - 1) begin
                chk("early_valid", 64'(out_valid), 64'd0);
                chk("busy_recv", 64'(busy), 64'd1);
            end
            bit_valid = 1'b1;
            bit_in = fb[i / 8][7 - (i % 8)];
            start = (i == ovr_bit);
            tick();
            bit_valid = 1'b0;
            start = 1'b0;
            if (i == ovr_bit) begin
                chk("overrun_pulse", 64'(overrun), 64'd1);
                tick();
                chk("overrun_clear", 64'(overrun), 64'd0);
            end
        end
    endtask

    task automatic check_result(input string tag);
        logic [63:0] expd;
        logic [7:0]  expm;
        logic        expe;
        expd = '0;
        for (int k = 0; k < fn; k++) expd |= 64'(fb[k]) << (8 * k);
        expm = 8'((16'd1 << fn) - 16'd1);
`ifdef CAN_RX_DLC_ERR_EN
        expe = (fdlc > 4'd8);
`else
        expe = 1'b0;
`endif
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_data"}, data_out, expd);
        chk({tag, "_mask"}, 64'(byte_mask), 64'(expm));
        chk({tag, "_dlc"}, 64'(dlc_out), 64'(fn));
        chk({tag, "_err"}, 64'(dlc_err), 64'(expe));
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("accept_valid", 64'(out_valid), 64'd0);
        chk("accept_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input logic [3:0] d, input bit gaps,
                             input string tag);
        begin_frame(d, 1'b0);
        feed(0, fn * 8, gaps, -1);
        check_result(tag);
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");

        begin_frame(4'd3, 1'b0);
        fb[0] = 8'hA5;
        fb[1] = 8'h3C;
        fb[2] = 8'hFF;
        feed(0, 24, 1'b0, -1);
        check_result("dlc3");
        chk("dlc3_const", data_out, 64'h0000_0000_00FF_3CA5);
        accept();

        begin_frame(4'd0, 1'b0);
        for (int c = 0; c < 5; c++) check_result("dlc0_hold");
        for (int c = 0; c < 5; c++) tick();
        check_result("dlc0_late");
        accept();

        run_frame(4'd8, 1'b1, "dlc8");
        held = data_out;
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'($urandom);
            tick();
        end
        bit_valid = 1'b0;
        chk("hold_stable", data_out, held);
        chk("hold_valid", 64'(out_valid), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_overrun", 64'(overrun), 64'd1);
        check_result("hold_after_ovr");
        accept();

        run_frame(4'hF, 1'b0, "dlcF");
        accept();

        begin_frame(4'd4, 1'b0);
        feed(0, 13, 1'b0, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_novalid", 64'(out_valid), 64'd0);
        end
        begin_frame(4'd1, 1'b0);
        fb[0] = 8'h81;
        feed(0, 8, 1'b0, -1);
        check_result("post_abort");
        chk("post_abort_const", data_out, 64'h81);
        accept();

        abort = 1'b1;
        start = 1'b1;
        dlc_in = 4'd2;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk_idle("abort_start");

        begin_frame(4'd2, 1'b0);
        feed(0, 16, 1'b0, 5);
        check_result("ovr_frame");
        begin_frame(4'd2, 1'b1);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_valid", 64'(out_valid), 64'd0);
        feed(0, 16, 1'b1, -1);
        check_result("b2b_frame");
        accept();

        begin_frame(4'd5, 1'b0);
        feed(0, 10, 1'b0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("mid_reset");
        run_frame(4'd6, 1'b1, "post_reset");
        accept();

        for (int f = 0; f < 16; f++) begin
            run_frame(4'($urandom_range(0, 15)), 1'($urandom), "rand");
            repeat ($urandom_range(0, 3)) tick();
            check_result("rand_wait");
            accept();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
